// File: rtl/rob_param_if.sv
// Reorder buffer bus: dispatch, writeback, operand read, retire and flush signals.
// slave = ROB side, master = pipeline side.
interface rob_param_if #(
   parameter int unsigned N_ENTRIES    = 16,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ARF_ID_WIDTH = 5,
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned N_WB_PORTS   = 2,
   parameter int unsigned N_RD_PORTS   = 2
);
   localparam int unsigned ID_W = $clog2(N_ENTRIES);

   logic                             dispatch_valid;
   logic                             dispatch_ready;
   logic [ID_W-1:0]                  dispatch_rob_id;
   logic                             dispatch_dst_valid;
   logic [ARF_ID_WIDTH-1:0]          dispatch_dst_arf_id;
   logic [PC_WIDTH-1:0]              dispatch_pc;
   logic [N_WB_PORTS-1:0]            wb_valid;
   logic [N_WB_PORTS*ID_W-1:0]       wb_rob_id;
   logic [N_WB_PORTS*DATA_WIDTH-1:0] wb_data;
   logic [N_WB_PORTS-1:0]            wb_mispred;
   logic [N_WB_PORTS*PC_WIDTH-1:0]   wb_npc;
   logic [N_RD_PORTS*ID_W-1:0]       rd_rob_id;
   logic [N_RD_PORTS-1:0]            rd_ready;
   logic [N_RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic                             retire;
   logic [ID_W-1:0]                  retire_rob_id;
   logic                             retire_wen;
   logic [ARF_ID_WIDTH-1:0]          retire_arf_id;
   logic [DATA_WIDTH-1:0]            retire_data;
   logic                             flush;
   logic [PC_WIDTH-1:0]              flush_pc;
   logic [ID_W:0]                    count;

   modport slave (
      input  dispatch_valid, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_pc,
      input  wb_valid, wb_rob_id, wb_data, wb_mispred, wb_npc, rd_rob_id,
      output dispatch_ready, dispatch_rob_id, rd_ready, rd_data,
      output retire, retire_rob_id, retire_wen, retire_arf_id, retire_data,
      output flush, flush_pc, count
   );

   modport master (
      output dispatch_valid, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_pc,
      output wb_valid, wb_rob_id, wb_data, wb_mispred, wb_npc, rd_rob_id,
      input  dispatch_ready, dispatch_rob_id, rd_ready, rd_data,
      input  retire, retire_rob_id, retire_wen, retire_arf_id, retire_data,
      input  flush, flush_pc, count
   );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order dispatch/retire, out-of-order writeback,
// mispredict flush with redirect PC, per-entry valid so stale writebacks are dropped.
// Optional macro ROB_WB_BYPASS_EN: same-cycle writeback is forwarded to read ports
// and to the retiring head entry.
module rob_param #(
   parameter int unsigned N_ENTRIES    = 16,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ARF_ID_WIDTH = 5,
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned N_WB_PORTS   = 2,
   parameter int unsigned N_RD_PORTS   = 2
) (
   input logic       clk,
   input logic       rst_aL,
   rob_param_if.slave bus
);
   localparam int unsigned ID_W = $clog2(N_ENTRIES);

   // Pointers carry an extra wrap bit to tell full from empty.
   logic [ID_W:0]           head_q, tail_q;
   logic [N_ENTRIES-1:0]    valid_q, done_q, mispred_q, dst_valid_q;
   logic [ARF_ID_WIDTH-1:0] arf_id_q [N_ENTRIES];
   logic [PC_WIDTH-1:0]     pc_q     [N_ENTRIES];
   logic [PC_WIDTH-1:0]     npc_q    [N_ENTRIES];
   logic [DATA_WIDTH-1:0]   data_q   [N_ENTRIES];

   logic [ID_W-1:0]       head_idx, tail_idx;
   logic                  empty, full, do_dispatch;
   logic                  head_hit, head_done, head_mispred;
   logic [DATA_WIDTH-1:0] head_data;
   logic [PC_WIDTH-1:0]   head_npc;

   logic [ID_W-1:0]       wb_id  [N_WB_PORTS];
   logic [DATA_WIDTH-1:0] wb_dat [N_WB_PORTS];
   logic [PC_WIDTH-1:0]   wb_pc  [N_WB_PORTS];
   logic [N_WB_PORTS-1:0] wb_acc;
   logic [ID_W-1:0]       rd_id  [N_RD_PORTS];

   assign head_idx = head_q[ID_W-1:0];
   assign tail_idx = tail_q[ID_W-1:0];
   assign empty    = (head_q == tail_q);
   assign full     = (head_idx == tail_idx) && (head_q[ID_W] != tail_q[ID_W]);

   // Unpack writeback ports; a writeback only counts when its target entry is live.
   always_comb begin
      for (int p = 0; p < N_WB_PORTS; p++) begin
         wb_id[p]  = bus.wb_rob_id[p*ID_W +: ID_W];
         wb_dat[p] = bus.wb_data[p*DATA_WIDTH +: DATA_WIDTH];
         wb_pc[p]  = bus.wb_npc[p*PC_WIDTH +: PC_WIDTH];
         wb_acc[p] = bus.wb_valid[p] & valid_q[wb_id[p]];
      end
   end

   // Head entry view, optionally merged with a same-cycle writeback (highest port wins).
   always_comb begin
      head_hit     = 1'b0;
      head_data    = data_q[head_idx];
      head_mispred = mispred_q[head_idx];
      head_npc     = npc_q[head_idx];
`ifdef ROB_WB_BYPASS_EN
      for (int p = 0; p < N_WB_PORTS; p++) begin
         if (wb_acc[p] && (wb_id[p] == head_idx)) begin
            head_hit     = 1'b1;
            head_data    = wb_dat[p];
            head_mispred = bus.wb_mispred[p];
            head_npc     = wb_pc[p];
         end
      end
`endif
   end

   assign head_done           = done_q[head_idx] | head_hit;
   assign bus.retire          = !empty && valid_q[head_idx] && head_done;
   assign bus.retire_rob_id   = head_idx;
   assign bus.retire_wen      = bus.retire & dst_valid_q[head_idx];
   assign bus.retire_arf_id   = arf_id_q[head_idx];
   assign bus.retire_data     = head_data;
   assign bus.flush           = bus.retire & head_mispred;
   assign bus.flush_pc        = head_npc;
   // No same-cycle slot reuse: a retire does not open a slot for dispatch while full.
   assign bus.dispatch_ready  = !full && !bus.flush;
   assign bus.dispatch_rob_id = tail_idx;
   assign bus.count           = tail_q - head_q;
   assign do_dispatch         = bus.dispatch_valid & bus.dispatch_ready;

   // Operand read ports on stored state, optionally forwarding same-cycle writebacks.
   always_comb begin
      bus.rd_ready = '0;
      bus.rd_data  = '0;
      for (int r = 0; r < N_RD_PORTS; r++) begin
         rd_id[r]        = bus.rd_rob_id[r*ID_W +: ID_W];
         bus.rd_ready[r] = valid_q[rd_id[r]] & done_q[rd_id[r]];
         bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_id[r]];
`ifdef ROB_WB_BYPASS_EN
         for (int p = 0; p < N_WB_PORTS; p++) begin
            if (wb_acc[p] && (wb_id[p] == rd_id[r])) begin
               bus.rd_ready[r] = 1'b1;
               bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = wb_dat[p];
            end
         end
`endif
      end
   end

   // Pointers and per-entry status bits; flush overrides retire on valid and tail.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         head_q    <= '0;
         tail_q    <= '0;
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
      end else begin
         if (do_dispatch) begin
            valid_q[tail_idx]   <= 1'b1;
            done_q[tail_idx]    <= 1'b0;
            mispred_q[tail_idx] <= 1'b0;
            tail_q              <= tail_q + 1'b1;
         end
         if (!bus.flush) begin
            for (int p = 0; p < N_WB_PORTS; p++) begin
               if (wb_acc[p]) begin
                  done_q[wb_id[p]]    <= 1'b1;
                  mispred_q[wb_id[p]] <= bus.wb_mispred[p];
               end
            end
         end
         if (bus.retire) begin
            valid_q[head_idx] <= 1'b0;
            head_q            <= head_q + 1'b1;
         end
         if (bus.flush) begin
            valid_q <= '0;
            tail_q  <= head_q + 1'b1;
         end
      end
   end

   // Entry payload; no reset needed since valid/done gate every use.
   always_ff @(posedge clk) begin
      if (do_dispatch) begin
         dst_valid_q[tail_idx] <= bus.dispatch_dst_valid;
         arf_id_q[tail_idx]    <= bus.dispatch_dst_arf_id;
         pc_q[tail_idx]        <= bus.dispatch_pc;
      end
      if (!bus.flush) begin
         for (int p = 0; p < N_WB_PORTS; p++) begin
            if (wb_acc[p]) begin
               data_q[wb_id[p]] <= wb_dat[p];
               npc_q[wb_id[p]]  <= wb_pc[p];
            end
         end
      end
   end
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_param;
   localparam int NE = 16;
   localparam int IW = 4;
   localparam int NW = 2;
   localparam int NR = 2;

   logic clk;
   logic rst_aL;
   int   checks = 0;
   int   errors = 0;

   rob_param_if #(.N_ENTRIES(NE), .DATA_WIDTH(32), .ARF_ID_WIDTH(5), .PC_WIDTH(32),
                  .N_WB_PORTS(NW), .N_RD_PORTS(NR)) bus ();

   rob_param #(.N_ENTRIES(NE), .DATA_WIDTH(32), .ARF_ID_WIDTH(5), .PC_WIDTH(32),
               .N_WB_PORTS(NW), .N_RD_PORTS(NR)) dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int          id;
      bit          dv;
      int          arf;
      bit          done;
      bit          mis;
      logic [31:0] data;
      logic [31:0] npc;
   } ent_t;

   typedef struct {
      int          id;
      bit          wen;
      int          arf;
      logic [31:0] data;
   } ret_t;

   ent_t mq[$];
   int   tail_ptr;
   ret_t rlog[$];

   // Reference model: in-flight entries kept as an ordered queue, oldest first.
   initial begin
      ent_t nq[$];
      ent_t eff[$];
      ent_t view[$];
      ent_t e;
      ret_t rr;
      int   ntail, head_ptr, id;
      bit   ret, fl, rdy, erdy;
      logic [31:0] ed;
      mq.delete();
      tail_ptr = 0;
      forever begin
         @(negedge clk);
         if (!rst_aL) begin
            chk("rst_count", 64'(bus.count), 0);
            chk("rst_ready", 64'(bus.dispatch_ready), 1);
            chk("rst_rob_id", 64'(bus.dispatch_rob_id), 0);
            chk("rst_retire", 64'(bus.retire), 0);
            chk("rst_wen", 64'(bus.retire_wen), 0);
            chk("rst_flush", 64'(bus.flush), 0);
            chk("rst_rd_ready", 64'(bus.rd_ready), 0);
            nq.delete();
            ntail = 0;
         end else begin
            eff = mq;
            for (int p = 0; p < NW; p++) begin
               if (bus.wb_valid[p]) begin
                  id = int'(bus.wb_rob_id[p*IW +: IW]);
                  for (int i = 0; i < eff.size(); i++) begin
                     if (eff[i].id == id) begin
                        e      = eff[i];
                        e.done = 1'b1;
                        e.data = bus.wb_data[p*32 +: 32];
                        e.mis  = bus.wb_mispred[p];
                        e.npc  = bus.wb_npc[p*32 +: 32];
                        eff[i] = e;
                     end
                  end
               end
            end
`ifdef ROB_WB_BYPASS_EN
            view = eff;
`else
            view = mq;
`endif
            ret = (view.size() > 0) && view[0].done;
            fl  = ret && view[0].mis;
            rdy = (mq.size() < NE) && !fl;
            chk("m_count", 64'(bus.count), 64'(mq.size()));
            chk("m_ready", 64'(bus.dispatch_ready), 64'(rdy));
            chk("m_rob_id", 64'(bus.dispatch_rob_id), 64'(tail_ptr % NE));
            chk("m_retire", 64'(bus.retire), 64'(ret));
            chk("m_flush", 64'(bus.flush), 64'(fl));
            if (ret) begin
               chk("m_ret_id", 64'(bus.retire_rob_id), 64'(view[0].id));
               chk("m_ret_wen", 64'(bus.retire_wen), 64'(view[0].dv));
               if (view[0].dv) begin
                  chk("m_ret_arf", 64'(bus.retire_arf_id), 64'(view[0].arf));
                  chk("m_ret_data", 64'(bus.retire_data), 64'(view[0].data));
               end
               if (fl) chk("m_flush_pc", 64'(bus.flush_pc), 64'(view[0].npc));
            end
            for (int r = 0; r < NR; r++) begin
               id   = int'(bus.rd_rob_id[r*IW +: IW]);
               erdy = 1'b0;
               ed   = '0;
               for (int i = 0; i < view.size(); i++) begin
                  if (view[i].id == id && view[i].done) begin
                     erdy = 1'b1;
                     ed   = view[i].data;
                  end
               end
               chk("m_rd_ready", 64'(bus.rd_ready[r]), 64'(erdy));
               if (erdy) chk("m_rd_data", 64'(bus.rd_data[r*32 +: 32]), 64'(ed));
            end
            if (bus.retire) begin
               rr.id   = int'(bus.retire_rob_id);
               rr.wen  = bus.retire_wen;
               rr.arf  = int'(bus.retire_arf_id);
               rr.data = bus.retire_data;
               rlog.push_back(rr);
            end
            head_ptr = (tail_ptr - mq.size() + 2 * NE) % (2 * NE);
            if (fl) begin
               nq.delete();
               ntail = (head_ptr + 1) % (2 * NE);
            end else begin
               nq = eff;
               if (ret) void'(nq.pop_front());
               ntail = tail_ptr;
               if (bus.dispatch_valid && rdy) begin
                  e.id   = tail_ptr % NE;
                  e.dv   = bus.dispatch_dst_valid;
                  e.arf  = int'(bus.dispatch_dst_arf_id);
                  e.done = 1'b0;
                  e.mis  = 1'b0;
                  e.data = '0;
                  e.npc  = '0;
                  nq.push_back(e);
                  ntail = (tail_ptr + 1) % (2 * NE);
               end
            end
         end
         @(posedge clk);
         mq       = nq;
         tail_ptr = ntail;
      end
   end

   task automatic idle();
      bus.dispatch_valid      = 1'b0;
      bus.dispatch_dst_valid  = 1'b0;
      bus.dispatch_dst_arf_id = '0;
      bus.dispatch_pc         = '0;
      bus.wb_valid            = '0;
      bus.wb_rob_id           = '0;
      bus.wb_data             = '0;
      bus.wb_mispred          = '0;
      bus.wb_npc              = '0;
      bus.rd_rob_id           = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst_aL = 1'b0;
      idle();
      tick();
      tick();
      rst_aL = 1'b1;
      rlog.delete();
   endtask

   task automatic disp(input bit dv, input int arf, input int pc);
      bus.dispatch_valid      = 1'b1;
      bus.dispatch_dst_valid  = dv;
      bus.dispatch_dst_arf_id = arf[4:0];
      bus.dispatch_pc         = pc;
   endtask

   task automatic wb(input int p, input int id, input logic [31:0] d, input bit mis,
                     input logic [31:0] npc);
      bus.wb_valid[p]            = 1'b1;
      bus.wb_rob_id[p*IW +: IW]  = id[IW-1:0];
      bus.wb_data[p*32 +: 32]    = d;
      bus.wb_mispred[p]          = mis;
      bus.wb_npc[p*32 +: 32]     = npc;
   endtask

   initial begin
      int wbs[6];
      bit seen;
      rst_aL = 1'b0;
      idle();
      do_reset();

      // Fill to full with no writebacks.
      for (int i = 0; i < 16; i++) begin
         disp(1'b1, i + 1, 32'h100 + i * 4);
         #1;
         chk("fill_rob_id", 64'(bus.dispatch_rob_id), 64'(i));
         chk("fill_ready", 64'(bus.dispatch_ready), 1);
         tick();
      end
      disp(1'b1, 3, 32'h200);
      #1;
      chk("full_count", 64'(bus.count), 16);
      chk("full_ready", 64'(bus.dispatch_ready), 0);
      chk("full_retire", 64'(bus.retire), 0);
      tick();
      chk("full_count_hold", 64'(bus.count), 16);

      // Out-of-order writeback, in-order retire, no-destination entry.
      do_reset();
      disp(1'b1, 1, 32'h0);  tick();
      disp(1'b1, 2, 32'h4);  tick();
      disp(1'b0, 0, 32'h8);  tick();
      wb(0, 2, 32'h22, 1'b0, 0); tick();
      wb(1, 0, 32'h20, 1'b0, 0); tick();
      wb(0, 1, 32'h21, 1'b0, 0); tick();
      tick(); tick(); tick();
      chk("ooo_n", 64'(rlog.size()), 3);
      if (rlog.size() == 3) begin
         chk("ooo_id0", 64'(rlog[0].id), 0);
         chk("ooo_id1", 64'(rlog[1].id), 1);
         chk("ooo_id2", 64'(rlog[2].id), 2);
         chk("ooo_wen0", 64'(rlog[0].wen), 1);
         chk("ooo_wen1", 64'(rlog[1].wen), 1);
         chk("ooo_wen2", 64'(rlog[2].wen), 0);
         chk("ooo_arf0", 64'(rlog[0].arf), 1);
         chk("ooo_arf1", 64'(rlog[1].arf), 2);
         chk("ooo_data0", 64'(rlog[0].data), 32'h20);
      end

      // Mispredict flush on id3.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         disp(1'b1, i + 1, i * 4);
         tick();
      end
      wbs = '{3, 0, 1, 2, 4, 5};
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (k < 6) wb(0, wbs[k], 32'h30 + k, (wbs[k] == 3), (wbs[k] == 3) ? 32'h200 : 32'h0);
         #1;
         if (bus.flush) begin
            seen = 1'b1;
            chk("fl_pc", 64'(bus.flush_pc), 32'h200);
            chk("fl_id", 64'(bus.retire_rob_id), 3);
            chk("fl_wen", 64'(bus.retire_wen), 1);
            chk("fl_arf", 64'(bus.retire_arf_id), 4);
            chk("fl_ready", 64'(bus.dispatch_ready), 0);
         end
         tick();
      end
      chk("fl_seen", 64'(seen), 1);
      chk("fl_count", 64'(bus.count), 0);
      chk("fl_next_id", 64'(bus.dispatch_rob_id), 4);
      chk("fl_retire", 64'(bus.retire), 0);
      chk("fl_nretired", 64'(rlog.size()), 4);
      wb(0, 4, 32'hdead, 1'b0, 0);
      tick();
      bus.rd_rob_id[0 +: IW] = 4'd4;
      #1;
      chk("fl_stale_rd", 64'(bus.rd_ready[0]), 0);
      tick();

      // Same-id writeback on both ports: port 1 wins.
      do_reset();
      disp(1'b1, 7, 32'h40); tick();
      wb(0, 0, 32'hAAAA, 1'b0, 0);
      wb(1, 0, 32'h5555, 1'b0, 0);
      tick(); tick();
      chk("conf_n", 64'(rlog.size()), 1);
      if (rlog.size() == 1) chk("conf_data", 64'(rlog[0].data), 32'h5555);

      // Continuous flow of 40 instructions, wrapping the ids.
      do_reset();
      for (int k = 0; k <= 42; k++) begin
         if (k < 40) disp(1'b1, (k % 31) + 1, k * 4);
         if (k >= 1 && k <= 40) wb(k % 2, (k - 1) % 16, 32'h1000 + k - 1, 1'b0, 0);
         tick();
      end
      chk("wrap_n", 64'(rlog.size()), 40);
      if (rlog.size() == 40) begin
         chk("wrap_id15", 64'(rlog[15].id), 15);
         chk("wrap_id16", 64'(rlog[16].id), 0);
         chk("wrap_id39", 64'(rlog[39].id), 7);
         chk("wrap_data39", 64'(rlog[39].data), 32'h1000 + 39);
      end
      chk("wrap_next_id", 64'(bus.dispatch_rob_id), 8);

      // Reset while entries are in flight.
      for (int i = 0; i < 3; i++) begin
         disp(1'b1, 1, 0);
         tick();
      end
      chk("mid_count_pre", 64'(bus.count), 3);
      rst_aL = 1'b0;
      #1;
      chk("mid_count", 64'(bus.count), 0);
      chk("mid_retire", 64'(bus.retire), 0);
      chk("mid_flush", 64'(bus.flush), 0);
      tick(); tick();
      rst_aL = 1'b1;

      // Writeback-to-read latency.
      do_reset();
      disp(1'b1, 1, 0); tick();
      disp(1'b1, 2, 4); tick();
      wb(0, 1, 32'h1234, 1'b0, 0);
      bus.rd_rob_id[0 +: IW] = 4'd1;
      #1;
`ifdef ROB_WB_BYPASS_EN
      chk("byp_rd_ready", 64'(bus.rd_ready[0]), 1);
      chk("byp_rd_data", 64'(bus.rd_data[31:0]), 32'h1234);
`else
      chk("nobyp_rd_ready", 64'(bus.rd_ready[0]), 0);
`endif
      tick();
      bus.rd_rob_id[0 +: IW] = 4'd1;
      #1;
      chk("lat_rd_ready", 64'(bus.rd_ready[0]), 1);
      chk("lat_rd_data", 64'(bus.rd_data[31:0]), 32'h1234);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer, the successor to the fixed single-configuration ROB.
- Sits between dispatch (enqueue), the execution writeback ports, the operand-read stage and the ARF (retire).
- Generalised depth, data width, writeback port count and read port count.
- New behaviour:
  - in-order retire of entries that have no destination;
  - a branch/load-mispredict flush that empties the ROB and emits a redirect PC;
  - per-entry valid tracking, so stale writebacks are ignored.

Parameters:
- N_ENTRIES, 16, entry count; power of two, at least 4.
- DATA_WIDTH, 32, register data width.
- ARF_ID_WIDTH, 5, architectural register id width.
- PC_WIDTH, 32, PC / redirect target width.
- N_WB_PORTS, 2, writeback ports (ALU, LSU, ...).
- N_RD_PORTS, 2, operand read ports.
- Derived: ID_W = $clog2(N_ENTRIES).

Ports:
- clk  in  1  clock.
- rst_aL  in  1  asynchronous active-low reset.
- dispatch_valid  in  1  dispatch has an instruction.
- dispatch_ready  out  1  ROB can accept one entry.
- dispatch_rob_id  out  ID_W  id the dispatched entry receives (current tail).
- dispatch_dst_valid  in  1  instruction writes a register.
- dispatch_dst_arf_id  in  ARF_ID_WIDTH  destination register.
- dispatch_pc  in  PC_WIDTH  instruction PC.
- wb_valid  in  N_WB_PORTS  per-port writeback strobe.
- wb_rob_id  in  N_WB_PORTS*ID_W  per-port target id.
- wb_data  in  N_WB_PORTS*DATA_WIDTH  result data.
- wb_mispred  in  N_WB_PORTS  result is a mispredict.
- wb_npc  in  N_WB_PORTS*PC_WIDTH  correct next PC; used only when wb_mispred=1.
- rd_rob_id  in  N_RD_PORTS*ID_W  operand lookup ids.
- rd_ready  out  N_RD_PORTS  entry valid and written back.
- rd_data  out  N_RD_PORTS*DATA_WIDTH  entry data.
- retire  out  1  head entry retires this cycle.
- retire_rob_id  out  ID_W  retiring id.
- retire_wen  out  1  ARF write enable (retire AND dst_valid).
- retire_arf_id  out  ARF_ID_WIDTH  ARF write address.
- retire_data  out  DATA_WIDTH  ARF write data.
- flush  out  1  mispredict flush pulse.
- flush_pc  out  PC_WIDTH  redirect target.
- count  out  ID_W+1  occupied entries.

Behaviour:
- Storage:
  - head and tail pointers, each ID_W+1 bits (wrap bit).
  - Per-entry fields: valid, done, mispred, dst_valid, arf_id, pc, data, npc.
- Conditions:
  - empty = (head == tail).
  - full = (index bits equal AND wrap bits differ).
  - count = tail - head, modulo 2^(ID_W+1).
- Reset (async, rst_aL=0):
  - head, tail and all valid/done/mispred bits cleared.
  - Outputs: dispatch_ready=1, dispatch_rob_id=0, retire=0, retire_wen=0, flush=0, count=0, rd_ready=0.
  - Data/pc fields need not be reset.
- Enqueue:
  - dispatch_ready = !full AND !flush.
  - On dispatch_valid AND dispatch_ready at the edge: entry[tail] written with valid=1, done=0, mispred=0; tail increments.
  - dispatch_rob_id equals the tail index combinationally.
- Writeback:
  - For each port p with wb_valid[p], the target entry is updated only if its valid bit is set: done=1, data, mispred, npc.
  - Writeback to an invalid entry is dropped silently.
  - Same id on several ports in one cycle: the highest port index wins.
- Retire:
  - Combinational; at most one per cycle.
  - retire = !empty AND entry[head].valid AND entry[head].done.
  - retire_wen = retire AND dst_valid.
  - Entries with no destination still retire, in order.
  - On retire at the edge: entry[head].valid is cleared and head increments.
- Flush:
  - flush = retire AND entry[head].mispred; flush_pc = entry[head].npc.
  - The mispredicted instruction itself retires and writes the ARF.
  - At the edge, all valid bits clear and tail is set to head+1, so the ROB is empty next cycle.
  - A dispatch in the flush cycle is refused (dispatch_ready=0).
  - Writebacks in the flush cycle are discarded.
- Simultaneous dispatch and retire while full: dispatch_ready stays 0 (no same-cycle slot reuse); count stays registered-consistent.
- Latency:
  - Writeback is visible on rd_ready/rd_data and on retire one cycle later.
  - Read ports are combinational on stored state.
- Wrap-around: index bits wrap modulo N_ENTRIES; the wrap bit toggles.
- Reset mid-operation: all in-flight entries are discarded immediately; no retire or flush pulse is generated.

Optional Feature:
- ROB_WB_BYPASS_EN defined:
  - A read port whose rd_rob_id matches a same-cycle valid writeback to a valid entry returns rd_ready=1 and the writeback data, with the highest matching port winning.
  - The head entry may retire in the same cycle as its writeback, using the writeback data and mispred/npc.
  - Write-to-retire latency becomes 0 cycles.
- Not defined: no bypass; 1-cycle latency as above.

Test Plan:
- Fill/full, default params:
  - Dispatch 16 entries with no writebacks -> ids 0..15, count=16, dispatch_ready=0 on cycle 17, retire=0 throughout.
- Out-of-order writeback:
  - Dispatch ids 0..2 (dst x1, x2, none); wb id2, then id0, then id1 -> retires in order 0, 1, 2.
  - retire_wen=1, 1, 0; retire_arf_id 1, 2.
- Mispredict flush:
  - Dispatch ids 0..5; wb id3 mispred npc=0x200; wb ids 0..2, 4, 5 -> ids 0..3 retire.
  - flush=1 with flush_pc=0x200 on id3's retire; count=0 next cycle; id 4/5 writebacks have no effect; next dispatch_rob_id=4.
- Write conflict:
  - wb port0 and port1 both to id0, data 0xAAAA / 0x5555 -> retire_data=0x5555.
- Wrap-around:
  - Cycle 40 instructions through a 16-entry ROB with continuous wb -> retire_rob_id sequence wraps 15->0; full never falsely asserted.
  - Mid-stream rst_aL low -> count=0 and retire=0 immediately.
- Bypass (ROB_WB_BYPASS_EN):
  - Read id1 in the same cycle as its wb of 0x1234 -> rd_ready=1, rd_data=0x1234.
  - Without the macro -> rd_ready=0 that cycle and 1 the next.
